// File: rtl/ddr2_power_ctrl.sv
// ddr2_power_ctrl
// Moves the DDR2 device into and out of the CKE-driven low-power modes
// (precharge power-down and self-refresh). While a low-power sequence is in
// progress this block owns the command bus and drives CKE plus the command
// pins. It enforces the minimum CKE-low residency and the NOP spacing after
// CKE is raised again.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-low reset
//   pd_req     : level request for precharge power-down
//   sr_req     : level request for self-refresh (wins over pd_req)
//   banks_idle : all banks precharged, scheduler has nothing in flight
//   cke, csbar, rasbar, casbar, webar : pad-stage CKE / command pins
//   cmd_own    : 1 = pad mux takes the pins from this block
//   ready      : 1 only in ACTIVE; scheduler may issue commands
//   pwr_state  : current state encoding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ACTIVE   | normal operation, scheduler owns the bus
// PD_ENTRY | one NOP cycle with CKE high before power-down
// PD       | power-down, CKE low, deselect; residency counter runs
// PD_EXIT  | CKE high, NOPs for tXP
// SR_ENTRY | one SELF-REFRESH command cycle with CKE high
// SR       | self-refresh, CKE low, deselect; residency counter runs
// SR_EXIT  | CKE high, NOPs for tXSNR

module ddr2_power_ctrl #(
    parameter int TCKE  = 3,
    parameter int TXP   = 2,
    parameter int TXSNR = 24,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pd_req,
    input  logic       sr_req,
    input  logic       banks_idle,
    output logic       cke,
    output logic       csbar,
    output logic       rasbar,
    output logic       casbar,
    output logic       webar,
    output logic       cmd_own,
    output logic       ready,
    output logic [2:0] pwr_state
);

    localparam logic [2:0] ACTIVE   = 3'd0;
    localparam logic [2:0] PD_ENTRY = 3'd1;
    localparam logic [2:0] PD       = 3'd2;
    localparam logic [2:0] PD_EXIT  = 3'd3;
    localparam logic [2:0] SR_ENTRY = 3'd4;
    localparam logic [2:0] SR       = 3'd5;
    localparam logic [2:0] SR_EXIT  = 3'd6;

    localparam logic [CW-1:0] TCKE_LOAD  = CW'(TCKE - 1);
    localparam logic [CW-1:0] TXP_LOAD   = CW'(TXP - 1);
    localparam logic [CW-1:0] TXSNR_LOAD = CW'(TXSNR - 1);

    logic [2:0]    state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          cke_next;
    logic [3:0]    pins_next;   // {csbar, rasbar, casbar, webar}
    logic          own_next;

    always_comb begin
        state_next = pwr_state;
        // Counter saturates at zero in the residency/exit states.
        count_next = (count == '0) ? '0 : count - CW'(1);
        case (pwr_state)
            ACTIVE: begin
                count_next = '0;
                if (banks_idle && sr_req)
                    state_next = SR_ENTRY;
                else if (banks_idle && pd_req)
                    state_next = PD_ENTRY;
            end
            PD_ENTRY: begin
                state_next = PD;
                count_next = TCKE_LOAD;
            end
            PD: begin
                if (count == '0 && !pd_req) begin
                    state_next = PD_EXIT;
                    count_next = TXP_LOAD;
                end
            end
            PD_EXIT: begin
                if (count == '0)
                    state_next = ACTIVE;
            end
            SR_ENTRY: begin
                state_next = SR;
                count_next = TCKE_LOAD;
            end
            SR: begin
                if (count == '0 && !sr_req) begin
                    state_next = SR_EXIT;
                    count_next = TXSNR_LOAD;
                end
            end
            SR_EXIT: begin
                if (count == '0)
                    state_next = ACTIVE;
            end
            default: begin
                state_next = ACTIVE;
                count_next = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so that every output is a
    // flop and always matches pwr_state in the same cycle.
    always_comb begin
        cke_next  = 1'b1;
        pins_next = 4'b1111;
        own_next  = 1'b1;
        case (state_next)
            ACTIVE:            own_next  = 1'b0;
            PD_ENTRY:          pins_next = 4'b0111;
            SR_ENTRY:          pins_next = 4'b0001;
            PD, SR:            cke_next  = 1'b0;
            PD_EXIT, SR_EXIT:  pins_next = 4'b0111;
            default:           own_next  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwr_state <= ACTIVE;
            count     <= '0;
            cke       <= 1'b1;
            csbar     <= 1'b1;
            rasbar    <= 1'b1;
            casbar    <= 1'b1;
            webar     <= 1'b1;
            cmd_own   <= 1'b0;
            ready     <= 1'b1;
        end else begin
            pwr_state <= state_next;
            count     <= count_next;
            cke       <= cke_next;
            {csbar, rasbar, casbar, webar} <= pins_next;
            cmd_own   <= own_next;
            ready     <= (state_next == ACTIVE);
        end
    end

endmodule

// File: doc/ddr2_power_ctrl.md
Name: ddr2_power_ctrl

Overview:
Sequencer that takes the DDR2 device into and out of CKE-driven low-power modes: precharge power-down and self-refresh. It sits between the controller's command scheduler and the pad stage, driving CKE and the command pins while a low-power mode is active. It enforces minimum CKE-low residency and exit-to-command spacing. It guarantees that only NOP/deselect is driven while CKE is low, which is the property checked downstream on the pads.

Parameters:
TCKE, 3, minimum cycles CKE stays low once lowered (tCKE).
TXP, 2, NOP cycles after power-down exit before ready (tXP).
TXSNR, 24, NOP cycles after self-refresh exit before ready (tXSNR).
CW, 8, counter width; must satisfy 2^CW > max(TCKE, TXP, TXSNR).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-low reset.
pd_req  input  1  level; request precharge power-down.
sr_req  input  1  level; request self-refresh; takes priority over pd_req.
banks_idle  input  1  all banks precharged and scheduler has no command in flight.
cke  output  1  CKE to pad stage.
csbar  output  1  CS# to pad stage (all ranks).
rasbar  output  1  RAS# to pad stage.
casbar  output  1  CAS# to pad stage.
webar  output  1  WE# to pad stage.
cmd_own  output  1  1 = this block owns the command bus; pad mux selects cke/csbar/rasbar/casbar/webar from this block.
ready  output  1  1 only in ACTIVE; scheduler may issue commands.
pwr_state  output  3  current state encoding (see below).

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) puts the block in ACTIVE: cke=1, csbar=rasbar=casbar=webar=1, cmd_own=0, ready=1, pwr_state=0, counter=0.
- Reset mid-operation takes effect on the next edge regardless of state. Exit timing is not honoured; the init sequencer is responsible for re-initialisation.
- State encodings: ACTIVE=0, PD_ENTRY=1, PD=2, PD_EXIT=3, SR_ENTRY=4, SR=5, SR_EXIT=6.
- ACTIVE:
  - cmd_own=0; ready=1.
  - If banks_idle && sr_req, go to SR_ENTRY.
  - Else if banks_idle && pd_req, go to PD_ENTRY.
  - Otherwise stay. A request without banks_idle waits with no timeout.
- PD_ENTRY (1 cycle): cmd_own=1, ready=0, cke=1, NOP (csbar=0, ras/cas/we=1). Next state PD; counter loaded with TCKE-1.
- PD:
  - cke=0, deselect (csbar=1, ras/cas/we=1).
  - Counter decrements to 0 and holds.
  - When counter==0 && !pd_req, go to PD_EXIT with counter=TXP-1.
  - sr_req asserting during PD is ignored until ACTIVE is reached.
- PD_EXIT: cke=1, NOP. Decrement counter; at 0, go to ACTIVE.
- SR_ENTRY (1 cycle): cmd_own=1, cke=1, SELF-REFRESH command (csbar=0, rasbar=0, casbar=0, webar=1). Next state SR; counter loaded with TCKE-1.
- SR: cke=0, deselect. Exit to SR_EXIT when counter==0 && !sr_req; counter loaded with TXSNR-1.
- SR_EXIT: cke=1, NOP. At counter 0, go to ACTIVE.
- Invariant: cke==0 implies csbar==1. No non-NOP command is ever driven while cke=0.
- Request deasserted before minimum residency: low power is held until counter==0, then exit begins on the next edge.
- Request reasserted during an exit state: the exit completes and at least one ACTIVE cycle (ready=1) follows before re-entry.
- Latencies:
  - ACTIVE with request and banks_idle → cke=0: 2 edges (entry state, then low-power state).
  - Request drop → ready: TXP+1 edges (PD) or TXSNR+1 edges (SR), provided residency has elapsed.
- Counters saturate at 0. A parameter value of 0 is illegal; only values ≥1 are supported.

Test Plan:
1. Reset held low 3 cycles while pd_req=1 → cke=1, cmd_own=0, ready=1, pwr_state=0 throughout. Release reset with banks_idle=0 → stays ACTIVE indefinitely.
2. banks_idle=1, pd_req pulsed for 1 cycle → pwr_state 1,2 with cke=0 for exactly 3 cycles (TCKE), then 3 for 2 cycles, then ready=1. csbar=1 on every cycle where cke=0.
3. sr_req=1 and pd_req=1 together, banks_idle=1 → SR_ENTRY chosen. Pins 0/0/0/1 with cke=1 for one cycle, then cke=0. Hold sr_req 50 cycles, then drop → cke=1 next edge, ready=1 after 24 NOP cycles.
4. In PD, assert sr_req then drop pd_req → PD exit completes to ACTIVE (one cycle, ready=1), then SR_ENTRY.
5. Reset asserted while in SR with cke=0 → next edge cke=1, pins all 1, cmd_own=0, pwr_state=0.
6. Random pd_req/sr_req/banks_idle for 10k cycles, with the pad-level power monitor attached → no monitor error. cke=0 never coincides with cmd_own=0.
